mem_write_monitor: RTL and testbench

Synthesizable run monitor that sits directly downstream of the microprogrammed RISC-V top. It consumes the processor's memory-write port plus the datapath's Instr and PC every cycle. It computes the 32-bit rolling signature hash and classifies the run as PASS, FAIL or TIMEOUT. It logs memory writes in a small FIFO that debug logic or FPGA I/O can drain.

---
 rtl/mon_pkg.sv | 28 ++
 rtl/write_log_fifo.sv | 55 +++++
 rtl/mem_write_monitor.sv | 91 +++++++++
 tb/tb_mem_write_monitor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// Shared types and the signature hash step for the run monitor.
package mon_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    PASS    = 3'd1,
    FAIL    = 3'd2,
    TIMEOUT = 3'd3
  } monitor_state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } log_entry_t;

  // One LFSR-style fold: mix the cycle's inputs in, shift left, feed back taps 31/30/29/9.
  function automatic logic [31:0] next_hash(input logic [31:0] hash,
                                            input logic [31:0] instr,
                                            input logic [31:0] pc,
                                            input logic        we,
                                            input logic [31:0] wd);
    logic [31:0] t;
    t = hash ^ instr ^ pc;
    if (we) t = t ^ wd;
    return {t[30:0], t[9] ^ t[29] ^ t[30] ^ t[31]};
  endfunction

endpackage

// File: rtl/write_log_fifo.sv
// Show-ahead FIFO for memory-write records with a sticky drop flag.
module write_log_fifo
  import mon_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = log_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full,
  output logic overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  T              mem [DEPTH];
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A push into a full log still lands when a pop frees the head slot on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? T'('0) : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_write_monitor.sv
// Run monitor: signature hash, PASS/FAIL/TIMEOUT classification and a write log.
module mem_write_monitor
  import mon_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000,
  parameter int          LOG_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        mem_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] write_data,
  output logic [2:0]  state,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] hash,
  output logic [15:0] cycle_count,
  input  logic        log_pop,
  output logic        log_empty,
  output logic        log_full,
  output logic        log_overflow,
  output logic [31:0] log_adr,
  output logic [31:0] log_data
);

  monitor_state_t state_q, state_d;
  logic           running;
  log_entry_t     push_entry, head_entry;

  assign running = (state_q == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Terminating writes are checked before the timeout so a write on the last cycle wins.
  always_comb begin
    state_d = state_q;
    if (running) begin
      if (mem_write && data_adr == PASS_ADDR && write_data == PASS_DATA)
        state_d = PASS;
      else if (mem_write && data_adr != SCRATCH_ADDR)
        state_d = FAIL;
      else if (cycle_count == TIMEOUT_CYCLES - 16'd1)
        state_d = TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hash        <= '0;
      cycle_count <= '0;
    end else if (running) begin
      hash <= next_hash(hash, instr, pc, mem_write, write_data);
      if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
    end
  end

  assign state   = state_q;
  assign pass    = (state_q == PASS);
  assign fail    = (state_q == FAIL);
  assign timeout = (state_q == TIMEOUT);

  assign push_entry = '{adr: data_adr, data: write_data};

  write_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .T     (log_entry_t)
  ) u_log (
    .clk      (clk),
    .reset    (reset),
    .push     (mem_write && running),
    .din      (push_entry),
    .pop      (log_pop),
    .head     (head_entry),
    .empty    (log_empty),
    .full     (log_full),
    .overflow (log_overflow)
  );

  assign log_adr  = head_entry.adr;
  assign log_data = head_entry.data;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed table, hand sequences and randomized runs against a queue-based model.
module tb_mem_write_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0, pc = '0, data_adr = '0, write_data = '0;
  logic        mem_write = 1'b0, log_pop = 1'b0;
  logic [2:0]  state;
  logic        pass, fail, timeout, log_empty, log_full, log_overflow;
  logic [31:0] hash, log_adr, log_data;
  logic [15:0] cycle_count;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mem_write_monitor #(
    .TIMEOUT_CYCLES (16'd10),
    .LOG_DEPTH      (8)
  ) dut (
    .clk (clk), .reset (reset), .instr (instr), .pc (pc),
    .mem_write (mem_write), .data_adr (data_adr), .write_data (write_data),
    .state (state), .pass (pass), .fail (fail), .timeout (timeout),
    .hash (hash), .cycle_count (cycle_count), .log_pop (log_pop),
    .log_empty (log_empty), .log_full (log_full), .log_overflow (log_overflow),
    .log_adr (log_adr), .log_data (log_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] i, input logic [31:0] p, input logic we,
                        input logic [31:0] a, input logic [31:0] d, input logic pp);
    instr = i; pc = p; mem_write = we; data_adr = a; write_data = d; log_pop = pp;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
  endtask

  // Reference: spec arithmetic, log as a queue
  int              m_st;           // 0 run, 1 pass, 2 fail, 3 timeout
  logic [31:0]     m_h;
  int              m_c;
  logic [63:0]     m_q[$];
  bit              m_ovf;

  function automatic logic [31:0] ref_hash(input logic [31:0] h, input logic [31:0] i,
                                           input logic [31:0] p, input bit we,
                                           input logic [31:0] d);
    logic [31:0] t;
    t = h ^ i ^ p ^ (we ? d : 32'd0);
    return (t << 1) | {31'd0, ^(t & 32'hE000_0200)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_h = 0; m_c = 0; m_q.delete(); m_ovf = 0;
  endtask

  task automatic model_step();
    bit pop_ok, push;
    int sz;
    sz = m_q.size();
    pop_ok = log_pop && sz > 0;
    push = 0;
    if (m_st == 0) begin
      push = mem_write;
      m_h = ref_hash(m_h, instr, pc, mem_write, write_data);
      if (mem_write && data_adr == 100 && write_data == 25) m_st = 1;
      else if (mem_write && data_adr != 96)                 m_st = 2;
      else if (m_c == 9)                                     m_st = 3;
      if (m_c < 65535) m_c++;
    end
    if (pop_ok) void'(m_q.pop_front());
    if (push) begin
      if (sz == 8 && !pop_ok) m_ovf = 1;
      else m_q.push_back({data_adr, write_data});
    end
  endtask

  task automatic model_cmp();
    logic [63:0] hd;
    hd = (m_q.size() > 0) ? m_q[0] : 64'd0;
    chk("rnd_state", {29'd0, state}, m_st);
    chk("rnd_flags", {29'd0, pass, fail, timeout},
        {29'd0, m_st == 1, m_st == 2, m_st == 3});
    chk("rnd_hash", hash, m_h);
    chk("rnd_cycle", {16'd0, cycle_count}, m_c);
    chk("rnd_logflags", {29'd0, log_empty, log_full, log_overflow},
        {29'd0, m_q.size() == 0, m_q.size() == 8, m_ovf});
    chk("rnd_logadr", log_adr, hd[63:32]);
    chk("rnd_logdata", log_data, hd[31:0]);
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] i, p;
    bit          we;
    logic [31:0] a, d;
    bit          pop;
    logic [2:0]  st;
    logic [15:0] cyc;
    logic [31:0] h;
    bit          empty;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1, 32'h1,        0, 0, 0,   0,  0, 3'd0, 16'd1, 32'h2,  1};
    vt[1] = '{1, 32'h80000000, 0, 0, 0,   0,  0, 3'd0, 16'd1, 32'h1,  1};
    vt[2] = '{1, 0,            0, 1, 96,  7,  0, 3'd0, 16'd1, 32'hE,  0};
    vt[3] = '{0, 0,            0, 1, 100, 25, 0, 3'd1, 16'd2, 32'h2E, 0};
    vt[4] = '{0, 0,            0, 0, 0,   0,  1, 3'd1, 16'd2, 32'h2E, 0};
    vt[5] = '{0, 0,            0, 0, 0,   0,  1, 3'd1, 16'd2, 32'h2E, 1};
    vt[6] = '{1, 0,            0, 1, 100, 24, 0, 3'd2, 16'd1, 32'h30, 0};
    vt[7] = '{1, 0,            0, 1, 64,  25, 0, 3'd2, 16'd1, 32'h32, 0};

    #1;
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_hash", hash, 0);
    chk("rst_empty", {31'd0, log_empty}, 1);

    for (int k = 0; k < 8; k++) begin
      if (vt[k].rst) do_reset();
      set_in(vt[k].i, vt[k].p, vt[k].we, vt[k].a, vt[k].d, vt[k].pop);
      if (k == 4) begin
        chk("pass_head0_adr", log_adr, 96);
        chk("pass_head0_dat", log_data, 7);
      end
      if (k == 5) chk("pass_head1_dat", log_data, 25);
      step();
      chk($sformatf("vec%0d_state", k), {29'd0, state}, {29'd0, vt[k].st});
      chk($sformatf("vec%0d_cycle", k), {16'd0, cycle_count}, {16'd0, vt[k].cyc});
      chk($sformatf("vec%0d_hash", k), hash, vt[k].h);
      chk($sformatf("vec%0d_empty", k), {31'd0, log_empty}, {31'd0, vt[k].empty});
      if (k == 7) chk("fail_head_adr", log_adr, 64);
    end

    // timeout after the 10th RUN edge
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 9) chk("to_pre_state", {29'd0, state}, 0);
    end
    chk("to_flag", {31'd0, timeout}, 1);
    chk("to_cycle", {16'd0, cycle_count}, 10);
    step();
    chk("to_frozen_cycle", {16'd0, cycle_count}, 10);

    // terminating write on the last cycle beats the timeout
    do_reset();
    for (int c = 1; c <= 9; c++) step();
    set_in(0, 0, 1, 100, 25, 0);
    step();
    chk("lastpass_flags", {29'd0, pass, fail, timeout}, 32'b100);

    // overflow: eight fill, ninth dropped, contents intact
    do_reset();
    for (int c = 0; c < 9; c++) begin
      set_in(0, 0, 1, 96, c, 0);
      step();
      if (c == 7) chk("ovf_full8", {30'd0, log_full, log_overflow}, 32'b10);
    end
    chk("ovf_sticky", {30'd0, log_full, log_overflow}, 32'b11);
    for (int c = 0; c < 8; c++) begin
      set_in(0, 0, 0, 0, 0, 1);
      chk($sformatf("ovf_entry%0d", c), log_data, c);
      step();
    end
    chk("ovf_drained", {30'd0, log_empty, log_overflow}, 32'b11);

    // push+pop while full: no overflow
    do_reset();
    for (int c = 0; c < 8; c++) begin set_in(0, 0, 1, 96, c + 10, 0); step(); end
    set_in(0, 0, 1, 96, 99, 1);
    step();
    chk("pp_flags", {30'd0, log_full, log_overflow}, 32'b10);
    chk("pp_head", log_data, 11);

    // asynchronous reset mid-run
    reset = 1'b0;
    #1;
    chk("midrst_outs", {state, pass, fail, timeout, log_empty, log_full, log_overflow},
        32'b000_000_100);
    chk("midrst_hash", hash, 0);
    chk("midrst_cycle", {16'd0, cycle_count}, 0);
    chk("midrst_log", log_adr | log_data, 0);
    #2 reset = 1'b1;

    // randomized runs against the model
    for (int r = 0; r < 60; r++) begin
      do_reset();
      model_reset();
      for (int c = 0; c < 14; c++) begin
        int sel;
        logic [31:0] a, d;
        sel = $urandom_range(0, 19);
        d = $urandom_range(0, 40);
        case (sel)
          10:      begin a = 100; d = 25; end
          11:      a = 100;
          12:      a = 64;
          13:      a = $urandom;
          default: a = 96;
        endcase
        set_in($urandom, $urandom, $urandom_range(0, 9) < 5, a, d, $urandom_range(0, 3) == 0);
        model_step();
        step();
        model_cmp();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
